// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding and default sizing for the data memory responder
package dmem_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;
    localparam int DEPTH_DEF = 64;
    localparam int LAT_DEF   = 2;
    localparam int CNT_W     = 4;
endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: MEM-stage request/response bundle
interface data_mem_responder_if;
    logic        MR;
    logic        MW;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        ack;
    logic        err;
    modport master (output MR, MW, addr, wdata, input rdata, stall, ack, err);
    modport slave  (input MR, MW, addr, wdata, output rdata, stall, ack, err);
endinterface

// File: rtl/dmem_wait_counter.sv
// dmem_wait_counter: loadable down-counter that flags its final wait cycle
module dmem_wait_counter
    import dmem_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] init,
    input  logic             dec,
    output logic             last
);
    logic [CNT_W-1:0] cnt;
    // load the wait length on acceptance, count down while busy, never wrap below zero
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt <= '0;
        else if (load) cnt <= init;
        else if (dec && cnt != '0) cnt <= cnt - 1'b1;
    assign last = cnt == CNT_W'(1);
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle register-array data memory with stall/ack/err handshake
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int LAT   = LAT_DEF
) (
    input logic                 clk,
    input logic                 reset,
    data_mem_responder_if.slave bus
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);
    state_t      state;
    logic [31:0] mem [DEPTH];
    logic [31:0] a_q, w_q, rdata_q;
    logic        wr_q, both_q, ack_q, err_q;
    logic        req, last, bad;
    logic [AW-1:0] idx;
    assign req = bus.MR || bus.MW;
    assign idx = a_q[AW+1:2];
    // out-of-range is judged on the full word address so aliases above DEPTH are rejected
    assign bad = a_q[1:0] != 2'b00 || a_q[31:2] >= DEPTH_W;
    assign bus.stall = reset && ((state == IDLE && req) || state == BUSY);
    assign bus.rdata = rdata_q;
    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    dmem_wait_counter u_wait (
        .clk   (clk),
        .reset (reset),
        .load  (state == IDLE && req),
        .init  (CNT_W'(LAT)),
        .dec   (state == BUSY),
        .last  (last)
    );
    // access FSM: latch request, wait LAT cycles, commit memory/rdata on entry to DONE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            a_q     <= '0;
            w_q     <= '0;
            wr_q    <= 1'b0;
            both_q  <= 1'b0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            ack_q <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    a_q    <= bus.addr;
                    w_q    <= bus.wdata;
                    wr_q   <= bus.MW;
                    both_q <= bus.MR && bus.MW;
                    err_q  <= 1'b0;
                    state  <= BUSY;
                end
                BUSY: if (last) begin
                    state <= DONE;
                    ack_q <= 1'b1;
                    err_q <= bad || both_q;
                    if (!bad) begin
                        if (wr_q) mem[idx] <= w_q;
                        else rdata_q <= mem[idx];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit words stored.
REQ-002 Parameter LAT, default 2, wait cycles spent in BUSY per access, legal range 1..15.
REQ-003 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 Port reset, input, 1, asynchronous, active-low reset.
REQ-005 Port MR, input, 1, read request from MEM stage.
REQ-006 Port MW, input, 1, write request from MEM stage.
REQ-007 Port addr, input, 32, byte address (ALU result from EX/MEM).
REQ-008 Port wdata, input, 32, store data.
REQ-009 Port rdata, output, 32, registered load data.
REQ-010 Port stall, output, 1, pipeline hold request.
REQ-011 Port ack, output, 1, access-complete pulse.
REQ-012 Port err, output, 1, registered sticky-until-next-access error flag.

Function
REQ-013 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-014 In IDLE with (MR|MW)=1, the block SHALL latch addr, wdata and op, load wait counter with LAT, and go to BUSY.
REQ-015 In BUSY, the counter SHALL decrement each cycle; at count 1 the next state SHALL be DONE.
REQ-016 DONE SHALL last exactly one cycle and then return to IDLE unconditionally; requests present during DONE SHALL be ignored.
REQ-017 stall SHALL be combinational: 1 when (IDLE and (MR|MW)) or BUSY, else 0.
REQ-018 ack SHALL be 1 only in DONE; request at cycle 0 gives ack at cycle LAT+1.
REQ-019 Word index SHALL be addr[log2(DEPTH)+1:2].
REQ-020 A write SHALL update memory on the BUSY-to-DONE edge; a read SHALL load rdata on the same edge.
REQ-021 rdata SHALL hold its value until the next successful read completes; writes leave rdata unchanged.
REQ-022 MR and MW both 1 in IDLE: treated as a write, err set at DONE.
REQ-023 addr[1:0]!=0 or word index >= DEPTH: no memory/rdata update, err=1 at DONE.
REQ-024 err SHALL be cleared on acceptance of the next request and otherwise held.
REQ-025 Reset assertion mid-access SHALL abort it with no memory write.

Reset
REQ-026 On reset low, the block SHALL asynchronously force state IDLE, counter 0, rdata 0, ack 0, err 0, and clear all memory words to 0.
REQ-027 stall SHALL be 0 during reset regardless of MR/MW.
REQ-028 The first request SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-029 Package dmem_pkg SHALL hold the state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10), DEPTH and LAT defaults.
REQ-030 The wait counter SHALL be sub-module dmem_wait_counter (load, decrement, last-count flag).
REQ-031 Memory SHALL be a register array inside data_mem_responder; no vendor RAM primitives.

Verification
REQ-032 Write MW=1 addr=0x10 wdata=0xDEADBEEF, LAT=2 -> stall 1 for cycles 0..2, ack at cycle 3, err 0.
REQ-033 Read MR=1 addr=0x10 after REQ-032 -> rdata=0xDEADBEEF at ack cycle 3; rdata held through later writes.
REQ-034 Read addr=0x12 -> err=1 at ack, rdata unchanged, memory unchanged.
REQ-035 Read addr=0x100 with DEPTH=64 -> err=1, no update.
REQ-036 MR=MW=1 addr=0x04 wdata=0x5 -> word 1 = 0x5, err=1.
REQ-037 Reset low during BUSY of write to addr=0x20 -> state IDLE, stall 0, word 8 stays 0.
